// File: rtl/logic_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : logic_arb_pkg
// Purpose : Shared widths, opcode encoding and FSM states for the shared
//           bitwise logic unit arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package logic_arb_pkg;

    localparam int XLEN_P = 32;

    typedef enum logic [1:0] {
        LOGIC_AND  = 2'b00,
        LOGIC_OR   = 2'b01,
        LOGIC_XOR  = 2'b10,
        LOGIC_ANDN = 2'b11
    } logic_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/logic_op_32bit.sv
`default_nettype none
// ============================================================================
// Module  : logic_op_32bit
// Purpose : Combinational 32-bit bitwise unit (AND / OR / XOR / ANDN).
// Revision: 1.0 - initial release
// ============================================================================
module logic_op_32bit
    import logic_arb_pkg::*;
(
    input  logic [1:0]        op_i,
    input  logic [XLEN_P-1:0] rs1_i,
    input  logic [XLEN_P-1:0] rs2_i,
    output logic [XLEN_P-1:0] rd_o
);

    always_comb begin
        rd_o = '0;
        case (op_i)
            LOGIC_AND:  rd_o = rs1_i & rs2_i;
            LOGIC_OR:   rd_o = rs1_i | rs2_i;
            LOGIC_XOR:  rd_o = rs1_i ^ rs2_i;
            LOGIC_ANDN: rd_o = rs1_i & ~rs2_i;
            default:    rd_o = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/logic_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : logic_unit_arbiter
// Purpose : Round-robin sharing of one bitwise logic unit between two
//           valid/ready requesters; result held until accepted.
// Option  : LOGIC_ARB_BYPASS_EN - compute at the request handshake and skip
//           the EXEC state (IDLE -> RESP).
// Revision: 1.0 - initial release
// ============================================================================
module logic_unit_arbiter
    import logic_arb_pkg::*;
#(
    parameter int XLEN = XLEN_P
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            req0_valid_i,
    output logic            req0_ready_o,
    input  logic [1:0]      req0_op_i,
    input  logic [XLEN-1:0] req0_rs1_i,
    input  logic [XLEN-1:0] req0_rs2_i,
    output logic            rsp0_valid_o,
    input  logic            rsp0_ready_i,
    output logic [XLEN-1:0] rsp0_rd_o,
    input  logic            req1_valid_i,
    output logic            req1_ready_o,
    input  logic [1:0]      req1_op_i,
    input  logic [XLEN-1:0] req1_rs1_i,
    input  logic [XLEN-1:0] req1_rs2_i,
    output logic            rsp1_valid_o,
    input  logic            rsp1_ready_i,
    output logic [XLEN-1:0] rsp1_rd_o,
    output logic            busy_o
);

    arb_state_e      r_state;
    arb_state_e      w_state_nxt;
    logic            r_grant;
    logic            r_last_grant;
    logic [XLEN-1:0] r_rd;

    logic            w_req_any;
    logic            w_grant;
    logic            w_hs;
    logic            w_rsp_ready;
    logic [1:0]      w_sel_op;
    logic [XLEN-1:0] w_sel_rs1;
    logic [XLEN-1:0] w_sel_rs2;
    logic [1:0]      w_alu_op;
    logic [XLEN-1:0] w_alu_rs1;
    logic [XLEN-1:0] w_alu_rs2;
    logic [XLEN-1:0] w_alu_rd;

    // On contention the requester that did not win last time goes first.
    assign w_req_any   = req0_valid_i | req1_valid_i;
    assign w_grant     = (req0_valid_i && req1_valid_i) ? ~r_last_grant : req1_valid_i;
    assign w_hs        = (r_state == IDLE) && w_req_any;
    assign w_rsp_ready = r_grant ? rsp1_ready_i : rsp0_ready_i;
    assign w_sel_op    = w_grant ? req1_op_i  : req0_op_i;
    assign w_sel_rs1   = w_grant ? req1_rs1_i : req0_rs1_i;
    assign w_sel_rs2   = w_grant ? req1_rs2_i : req0_rs2_i;

`ifdef LOGIC_ARB_BYPASS_EN
    assign w_alu_op  = w_sel_op;
    assign w_alu_rs1 = w_sel_rs1;
    assign w_alu_rs2 = w_sel_rs2;
`else
    logic [1:0]      r_op;
    logic [XLEN-1:0] r_rs1;
    logic [XLEN-1:0] r_rs2;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_op  <= '0;
            r_rs1 <= '0;
            r_rs2 <= '0;
        end else if (w_hs) begin
            r_op  <= w_sel_op;
            r_rs1 <= w_sel_rs1;
            r_rs2 <= w_sel_rs2;
        end
    end

    assign w_alu_op  = r_op;
    assign w_alu_rs1 = r_rs1;
    assign w_alu_rs2 = r_rs2;
`endif

    logic_op_32bit u_logic_op (
        .op_i  (w_alu_op),
        .rs1_i (w_alu_rs1),
        .rs2_i (w_alu_rs2),
        .rd_o  (w_alu_rd)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
`ifdef LOGIC_ARB_BYPASS_EN
                if (w_hs) w_state_nxt = RESP;
`else
                if (w_hs) w_state_nxt = EXEC;
`endif
            end
            EXEC:    w_state_nxt = RESP;
            RESP:    if (w_rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req0_ready_o = 1'b0;
        req1_ready_o = 1'b0;
        rsp0_valid_o = 1'b0;
        rsp1_valid_o = 1'b0;
        rsp0_rd_o    = '0;
        rsp1_rd_o    = '0;
        busy_o       = (r_state != IDLE);
        if (r_state == IDLE && w_req_any) begin
            req0_ready_o = ~w_grant;
            req1_ready_o = w_grant;
        end
        if (r_state == RESP) begin
            if (r_grant) begin
                rsp1_valid_o = 1'b1;
                rsp1_rd_o    = r_rd;
            end else begin
                rsp0_valid_o = 1'b1;
                rsp0_rd_o    = r_rd;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_rd         <= '0;
        end else begin
            if (w_hs) r_grant <= w_grant;
`ifdef LOGIC_ARB_BYPASS_EN
            if (w_hs) r_rd <= w_alu_rd;
`else
            if (r_state == EXEC) r_rd <= w_alu_rd;
`endif
            if (r_state == RESP && w_rsp_ready) r_last_grant <= r_grant;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_logic_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_logic_unit_arbiter
// Purpose : Directed self-checking bench for logic_unit_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
module tb_logic_unit_arbiter;

`ifdef LOGIC_ARB_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req0_valid_i, req1_valid_i;
    logic        req0_ready_o, req1_ready_o;
    logic [1:0]  req0_op_i, req1_op_i;
    logic [31:0] req0_rs1_i, req0_rs2_i, req1_rs1_i, req1_rs2_i;
    logic        rsp0_valid_o, rsp1_valid_o;
    logic        rsp0_ready_i, rsp1_ready_i;
    logic [31:0] rsp0_rd_o, rsp1_rd_o;
    logic        busy_o;

    int n_checks = 0;
    int n_errors = 0;

    logic_unit_arbiter #(.XLEN(32)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req0_valid_i (req0_valid_i),
        .req0_ready_o (req0_ready_o),
        .req0_op_i    (req0_op_i),
        .req0_rs1_i   (req0_rs1_i),
        .req0_rs2_i   (req0_rs2_i),
        .rsp0_valid_o (rsp0_valid_o),
        .rsp0_ready_i (rsp0_ready_i),
        .rsp0_rd_o    (rsp0_rd_o),
        .req1_valid_i (req1_valid_i),
        .req1_ready_o (req1_ready_o),
        .req1_op_i    (req1_op_i),
        .req1_rs1_i   (req1_rs1_i),
        .req1_rs2_i   (req1_rs2_i),
        .rsp1_valid_o (rsp1_valid_o),
        .rsp1_ready_i (rsp1_ready_i),
        .rsp1_rd_o    (rsp1_rd_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_req(input int idx, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if (idx == 1) begin
            req1_valid_i = 1'b1; req1_op_i = op; req1_rs1_i = a; req1_rs2_i = b;
        end else begin
            req0_valid_i = 1'b1; req0_op_i = op; req0_rs1_i = a; req0_rs2_i = b;
        end
    endtask

    task automatic reset_dut();
        rst_ni = 1'b0;
        req0_valid_i = 0; req1_valid_i = 0; rsp0_ready_i = 0; rsp1_ready_i = 0;
        req0_op_i = 0; req1_op_i = 0;
        req0_rs1_i = 0; req0_rs2_i = 0; req1_rs1_i = 0; req1_rs2_i = 0;
        tick();
        tick();
        rst_ni = 1'b1;
        #1;
    endtask

    // Expects to be called in IDLE with requester idx presented and winning.
    task automatic serve(input int idx, input logic [31:0] exp_rd, input bit drop, input string tag);
        check({tag, "_ready"},     idx == 1 ? req1_ready_o : req0_ready_o, 1);
        check({tag, "_ready_oth"}, idx == 1 ? req0_ready_o : req1_ready_o, 0);
        tick();
        if (drop) begin
            if (idx == 1) req1_valid_i = 0; else req0_valid_i = 0;
        end
        for (int i = 1; i < LAT; i++) begin
            check({tag, "_exec_busy"},  busy_o, 1);
            check({tag, "_exec_valid"}, idx == 1 ? rsp1_valid_o : rsp0_valid_o, 0);
            check({tag, "_exec_rdy"},   req0_ready_o | req1_ready_o, 0);
            tick();
        end
        check({tag, "_rsp_valid"}, idx == 1 ? rsp1_valid_o : rsp0_valid_o, 1);
        check({tag, "_rsp_rd"},    idx == 1 ? rsp1_rd_o : rsp0_rd_o, exp_rd);
        check({tag, "_oth_valid"}, idx == 1 ? rsp0_valid_o : rsp1_valid_o, 0);
        check({tag, "_oth_rd"},    idx == 1 ? rsp0_rd_o : rsp1_rd_o, 0);
        if (idx == 1) rsp1_ready_i = 1; else rsp0_ready_i = 1;
        tick();
        rsp0_ready_i = 0;
        rsp1_ready_i = 0;
        check({tag, "_done_valid"}, rsp0_valid_o | rsp1_valid_o, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_dut();
        check("rst_busy", busy_o, 0);
        check("rst_valid", {rsp0_valid_o, rsp1_valid_o, req0_ready_o, req1_ready_o}, 0);
        check("rst_rd0", rsp0_rd_o, 0);
        check("rst_rd1", rsp1_rd_o, 0);

        // Single AND on requester 0
        set_req(0, 2'b00, 32'hF0F0_1234, 32'h0FF0_FFFF);
        #1;
        serve(0, 32'h00F0_1234, 1, "and0");
        check("and0_idle_busy", busy_o, 0);

        // Both continuously valid from reset: strict alternation 0,1,0,1
        reset_dut();
        set_req(0, 2'b01, 32'h0000_00FF, 32'hFF00_0000);
        set_req(1, 2'b10, 32'hAAAA_AAAA, 32'hFFFF_FFFF);
        #1;
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) serve(0, 32'hFF00_00FF, 0, "alt0");
            else            serve(1, 32'h5555_5555, 0, "alt1");
        end
        req0_valid_i = 0;
        req1_valid_i = 0;

        // ANDN from requester 0 alone, then contention favours requester 1
        set_req(0, 2'b11, 32'hFFFF_FFFF, 32'h0000_FFFF);
        #1;
        serve(0, 32'hFFFF_0000, 1, "andn0");
        set_req(0, 2'b00, 32'h1234_5678, 32'hFFFF_0000);
        set_req(1, 2'b01, 32'h0000_0001, 32'h8000_0000);
        #1;
        serve(1, 32'h8000_0001, 1, "pair_r1");
        serve(0, 32'h1234_0000, 1, "pair_r0");

        // Backpressure on response 0 while requester 1 waits
        set_req(0, 2'b10, 32'h0F0F_0F0F, 32'h00FF_00FF);
        #1;
        check("bp_ready0", req0_ready_o, 1);
        tick();
        req0_valid_i = 0;
        set_req(1, 2'b00, 32'hDEAD_BEEF, 32'hFFFF_0000);
        for (int i = 1; i < LAT; i++) tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", rsp0_valid_o, 1);
            check("bp_rd", rsp0_rd_o, 32'h0FF0_0FF0);
            check("bp_req1_ready", req1_ready_o, 0);
            tick();
        end
        rsp0_ready_i = 1;
        tick();
        rsp0_ready_i = 0;
        check("bp_rel_valid", rsp0_valid_o, 0);
        serve(1, 32'hDEAD_0000, 1, "bp_r1");

        // Asynchronous reset while an operation is in flight
        set_req(0, 2'b01, 32'h1111_0000, 32'h0000_2222);
        #1;
        tick();
        req0_valid_i = 0;
        check("ar_busy_pre", busy_o, 1);
        #2;
        rst_ni = 0;
        #1;
        check("ar_busy", busy_o, 0);
        check("ar_valid", {rsp0_valid_o, rsp1_valid_o}, 0);
        check("ar_rd0", rsp0_rd_o, 0);
        tick();
        rst_ni = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ar_stale_valid", {rsp0_valid_o, rsp1_valid_o}, 0);
            check("ar_stale_busy", busy_o, 0);
        end
        set_req(0, 2'b00, 32'hFFFF_FFFF, 32'h0000_00F0);
        set_req(1, 2'b00, 32'hFFFF_FFFF, 32'h0000_000F);
        #1;
        serve(0, 32'h0000_00F0, 1, "ar_r0");
        serve(1, 32'h0000_000F, 1, "ar_r1");

        // Requester 1 withdraws during requester 0's response
        set_req(0, 2'b01, 32'h0000_000F, 32'h0000_00F0);
        #1;
        tick();
        req0_valid_i = 0;
        for (int i = 1; i < LAT; i++) tick();
        check("wd_valid", rsp0_valid_o, 1);
        set_req(1, 2'b10, 32'h1234_5678, 32'h1111_1111);
        tick();
        check("wd_req1_ready", req1_ready_o, 0);
        req1_valid_i = 0;
        rsp0_ready_i = 1;
        tick();
        rsp0_ready_i = 0;
        check("wd_idle_busy", busy_o, 0);
        check("wd_no_ready", req1_ready_o, 0);
        tick();
        check("wd_stay_idle", busy_o, 0);
        check("wd_no_rsp", {rsp0_valid_o, rsp1_valid_o}, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
